riscv_load_store_unit: RTL and testbench
========================================

Name: riscv_load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU/EXECUTE stage of the multi-cycle RISC-V SOC core.
- Consumes the effective address (rs1+imm from the ALU), rs2, funct3 and the load/store decode; performs one byte/halfword/word access over a req/ready word-memory port.
- Returns a sign/zero-extended load result for register write-back, or a fault for a misaligned/illegal access or a timeout.

Parameters:
- ADDR_WIDTH, 32: byte-address width; mem_addr is the word address ADDR_WIDTH-2 bits wide.
- WAIT_LIMIT, 0: maximum cycles in ACCESS waiting for mem_ready; 0 disables the timeout.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- start  in  1  one-cycle request from EXECUTE (isLoad|isStore); ignored while busy
- is_store  in  1  1=store, 0=load
- funct3  in  3  RV32I width/sign code
- addr  in  ADDR_WIDTH  effective byte address
- store_data  in  32  rs2 value
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses (inclusive)
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1=misaligned, illegal funct3 or timeout
- load_data  out  32  formatted load result; valid with done when !fault && !is_store
- mem_req  out  1  memory request, held until mem_ready
- mem_addr  out  ADDR_WIDTH-2  word address = addr[ADDR_WIDTH-1:2]
- mem_wmask  out  4  byte write enables; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, sampled with mem_ready
- mem_ready  in  1  access complete this cycle

Behaviour:
- Reset (RESET==0 at a CLK edge): state=IDLE; busy, done, fault, mem_req, mem_wmask=0; load_data=0; wait counter=0. Also applies mid-access: mem_req drops after that edge and no done is issued.
- States: IDLE, ACCESS, RESP.
- IDLE + start, legal and aligned:
  - Latch is_store, funct3, addr, store_data; go to ACCESS.
  - From the next cycle: mem_req=1; mem_addr, mem_wmask, mem_wdata stable.
- IDLE + start, illegal or misaligned:
  - Go to RESP with fault=1; no mem_req; load_data unchanged.
  - Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
- ACCESS:
  - mem_ready=1 at an edge: capture the formatted read (loads only); go to RESP with fault=0.
  - Otherwise increment the wait counter. When WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT: go to RESP with fault=1 and drop mem_req.
- RESP: done=1 for exactly one cycle; return to IDLE. A start coinciding with RESP is ignored; start is accepted only in IDLE.
- Latency:
  - Fault-free: start at cycle 0; mem_req cycles 1..k (k = first cycle with mem_ready=1); done at k+1.
  - Zero-wait memory: done at cycle 2.
  - Early fault: done at cycle 1.
- busy = (state != IDLE).
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wmask=0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wmask=0011<<{addr[1],0}.
  - SW: wdata=sd, wmask=1111.
- Load formatting:
  - Byte = rdata[8*addr[1:0]+:8]; halfword = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- load_data holds its value between accesses; a store or a fault leaves it unchanged.
- Inputs other than start are don't-care outside the start cycle.

Decomposition:
- Shared package riscv_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state encoding: IDLE, ACCESS, RESP.
- Combinational sub-module riscv_lsu_align:
  - Inputs: funct3, addr[1:0], store_data, mem_rdata.
  - Outputs: wmask, wdata, formatted load word, misaligned, illegal.
- The top module holds the FSM, input latches, wait counter and output registers.

Test Plan:
- LW at addr=0x10, mem_rdata=0xDEADBEEF, ready on the first req cycle -> mem_addr=0x4, wmask=0000, done at cycle 2, load_data=0xDEADBEEF, fault=0.
- LB at addr=0x13, rdata=0x80FF1234 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU at addr=0x12 -> 0x000080FF.
- SB at addr=0x21, sd=0x000000A5 -> wmask=0010, wdata=0xA5A5A5A5; SH at addr=0x22, sd=0x1234 -> wmask=1100, wdata=0x12341234.
- LW at addr=0x0E -> no mem_req, done+fault at cycle 1; store with funct3=100 -> same; load_data unchanged.
- mem_ready held low, WAIT_LIMIT=4 -> mem_req for 4 cycles then drops; done+fault=1. Second start issued while busy -> ignored.
- RESET=0 during ACCESS -> mem_req=0, busy=0, no done; a fresh LW afterwards completes normally.

Source files
------------

// File: rtl/riscv_load_store_unit_pkg.sv
// Shared RV32I constants and the LSU state encoding used by the load/store unit.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/riscv_load_store_unit_if.sv
// Word-memory port between the LSU (master) and the data memory (slave).
interface riscv_load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  req;
  logic [ADDR_WIDTH-3:0] addr;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ready;

  modport master (
    output req, addr, wmask, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, addr, wmask, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction
// and extension, plus the misalignment and illegal-encoding checks.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        isStore_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] storeData_i,
  input  logic [31:0] memRdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loadWord_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel      = memRdata_i[{addrLo_i, 3'b000} +: 8];
    halfSel      = memRdata_i[{addrLo_i[1], 4'b0000} +: 16];
    wmask_o      = 4'b0000;
    wdata_o      = storeData_i;
    loadWord_o   = 32'h0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;

    unique case (funct3_i)
      F3_B: begin
        wmask_o    = 4'b0001 << addrLo_i;
        wdata_o    = {4{storeData_i[7:0]}};
        loadWord_o = {{24{byteSel[7]}}, byteSel};
      end
      F3_H: begin
        misaligned_o = addrLo_i[0];
        wmask_o      = 4'b0011 << {addrLo_i[1], 1'b0};
        wdata_o      = {2{storeData_i[15:0]}};
        loadWord_o   = {{16{halfSel[15]}}, halfSel};
      end
      F3_W: begin
        misaligned_o = (addrLo_i != 2'b00);
        wmask_o      = 4'b1111;
        loadWord_o   = memRdata_i;
      end
      F3_BU: begin
        illegal_o  = isStore_i;
        loadWord_o = {24'h0, byteSel};
      end
      F3_HU: begin
        illegal_o    = isStore_i;
        misaligned_o = addrLo_i[0];
        loadWord_o   = {16'h0, halfSel};
      end
      default: illegal_o = 1'b1;
    endcase

    // Loads never write memory.
    if (!isStore_i) wmask_o = 4'b0000;
  end

endmodule

// File: rtl/riscv_load_store_unit.sv
// Memory-access stage: accepts one load/store from EXECUTE, runs it over a
// req/ready word port and returns a formatted load result or a fault.
module riscv_load_store_unit
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  isStore_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           storeData_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [31:0]           loadData_o,
  riscv_load_store_unit_if.master mem
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(WAIT_LIMIT);

  lsu_state_e            state_q;
  logic                  isStore_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addrLo_q;
  logic [ADDR_WIDTH-3:0] memAddr_q;
  logic [3:0]            memWmask_q;
  logic [31:0]           memWdata_q;
  logic                  memReq_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  fault_q;
  logic [31:0]           loadData_q;
  logic [CW-1:0]         cnt_q;
  logic [CW:0]           cnt_d;

  logic                  idle;
  logic [2:0]            selFunct3;
  logic                  selIsStore;
  logic [1:0]            selAddrLo;
  logic [3:0]            alignWmask;
  logic [31:0]           alignWdata;
  logic [31:0]           alignLoad;
  logic                  alignMisaligned;
  logic                  alignIllegal;

  // In IDLE the aligner checks the incoming request; afterwards it formats
  // the read word using the latched request.
  assign idle       = (state_q == IDLE);
  assign selFunct3  = idle ? funct3_i       : funct3_q;
  assign selIsStore = idle ? isStore_i      : isStore_q;
  assign selAddrLo  = idle ? addr_i[1:0]    : addrLo_q;
  assign cnt_d      = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  riscv_lsu_align u_align (
    .funct3_i     (selFunct3),
    .isStore_i    (selIsStore),
    .addrLo_i     (selAddrLo),
    .storeData_i  (storeData_i),
    .memRdata_i   (mem.rdata),
    .wmask_o      (alignWmask),
    .wdata_o      (alignWdata),
    .loadWord_o   (alignLoad),
    .misaligned_o (alignMisaligned),
    .illegal_o    (alignIllegal)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      isStore_q  <= 1'b0;
      funct3_q   <= 3'b000;
      addrLo_q   <= 2'b00;
      memAddr_q  <= '0;
      memWmask_q <= 4'b0000;
      memWdata_q <= 32'h0;
      memReq_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      loadData_q <= 32'h0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            isStore_q <= isStore_i;
            funct3_q  <= funct3_i;
            addrLo_q  <= addr_i[1:0];
            memAddr_q <= addr_i[ADDR_WIDTH-1:2];
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            if (alignIllegal || alignMisaligned) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              memReq_q   <= 1'b1;
              memWmask_q <= alignWmask;
              memWdata_q <= alignWdata;
              fault_q    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (mem.ready) begin
            if (!isStore_q) loadData_q <= alignLoad;
            state_q    <= RESP;
            memReq_q   <= 1'b0;
            memWmask_q <= 4'b0000;
            done_q     <= 1'b1;
            fault_q    <= 1'b0;
          end else if ((WAIT_LIMIT != 0) && (cnt_d == LIMIT)) begin
            state_q    <= RESP;
            memReq_q   <= 1'b0;
            memWmask_q <= 4'b0000;
            done_q     <= 1'b1;
            fault_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_d[CW-1:0];
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fault_o    = fault_q;
  assign loadData_o = loadData_q;
  assign mem.req    = memReq_q;
  assign mem.addr   = memAddr_q;
  assign mem.wmask  = memWmask_q;
  assign mem.wdata  = memWdata_q;

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Directed, table-driven check of the load/store unit with a hand-driven
// memory port, plus sequences for timeout, busy-ignore and mid-access reset.
module tb_riscv_load_store_unit;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] loadData;

  int compared = 0;
  int mismatched = 0;

  riscv_load_store_unit_if #(.ADDR_WIDTH(32)) memIf ();

  riscv_load_store_unit #(
    .ADDR_WIDTH (32),
    .WAIT_LIMIT (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .start_i     (start),
    .isStore_i   (isStore),
    .funct3_i    (funct3),
    .addr_i      (addr),
    .storeData_i (storeData),
    .busy_o      (busy),
    .done_o      (done),
    .fault_o     (fault),
    .loadData_o  (loadData),
    .mem         (memIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [31:0] rdata;
    logic        expFault;
    logic [29:0] expMemAddr;
    logic [3:0]  expWmask;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start at cycle 0; a good access gets ready on its first req cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    start     = 1'b1;
    isStore   = v.isStore;
    funct3    = v.funct3;
    addr      = v.addr;
    storeData = v.storeData;
    memIf.rdata = v.rdata;
    memIf.ready = 1'b0;
    nextCycle();
    start = 1'b0;
    if (v.expFault) begin
      checkOutput($sformatf("v%0d_c1_done", idx), 32'(done), 32'd1);
      checkOutput($sformatf("v%0d_c1_fault", idx), 32'(fault), 32'd1);
      checkOutput($sformatf("v%0d_c1_req", idx), 32'(memIf.req), 32'd0);
      checkOutput($sformatf("v%0d_load", idx), loadData, v.expLoad);
    end else begin
      checkOutput($sformatf("v%0d_c1_req", idx), 32'(memIf.req), 32'd1);
      checkOutput($sformatf("v%0d_c1_busy", idx), 32'(busy), 32'd1);
      checkOutput($sformatf("v%0d_c1_done", idx), 32'(done), 32'd0);
      checkOutput($sformatf("v%0d_maddr", idx), 32'(memIf.addr), 32'(v.expMemAddr));
      checkOutput($sformatf("v%0d_wmask", idx), 32'(memIf.wmask), 32'(v.expWmask));
      if (v.isStore) checkOutput($sformatf("v%0d_wdata", idx), memIf.wdata, v.expWdata);
      memIf.ready = 1'b1;
      nextCycle();
      memIf.ready = 1'b0;
      checkOutput($sformatf("v%0d_c2_done", idx), 32'(done), 32'd1);
      checkOutput($sformatf("v%0d_c2_fault", idx), 32'(fault), 32'd0);
      checkOutput($sformatf("v%0d_c2_busy", idx), 32'(busy), 32'd1);
      checkOutput($sformatf("v%0d_c2_req", idx), 32'(memIf.req), 32'd0);
      checkOutput($sformatf("v%0d_load", idx), loadData, v.expLoad);
    end
    nextCycle();
    checkOutput($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d_idle_done", idx), 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t freshLw;

    //           st  f3      addr          sd            rdata         flt mAddr      wmask    wdata         load
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 30'h4, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'h80FF_1234, 1'b0, 30'h4, 4'b0000, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h80FF_1234, 1'b0, 30'h4, 4'b0000, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h80FF_1234, 1'b0, 30'h4, 4'b0000, 32'h0,         32'h0000_80FF};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0010, 32'h0,         32'h80FF_1234, 1'b0, 30'h4, 4'b0000, 32'h0,         32'h0000_1234};
    vecs[5]  = '{1'b1, 3'b000, 32'h0000_0021, 32'h0000_00A5, 32'h0,         1'b0, 30'h8, 4'b0010, 32'hA5A5_A5A5, 32'h0000_1234};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_0022, 32'h0000_1234, 32'h0,         1'b0, 30'h8, 4'b1100, 32'h1234_1234, 32'h0000_1234};
    vecs[7]  = '{1'b1, 3'b010, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,         1'b0, 30'h9, 4'b1111, 32'hCAFE_F00D, 32'h0000_1234};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_000E, 32'h0,         32'h0,         1'b1, 30'h0, 4'b0000, 32'h0,         32'h0000_1234};
    vecs[9]  = '{1'b1, 3'b100, 32'h0000_0020, 32'h0000_0055, 32'h0,         1'b1, 30'h0, 4'b0000, 32'h0,         32'h0000_1234};
    vecs[10] = '{1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 30'h0, 4'b0000, 32'h0,         32'h0000_1234};
    vecs[11] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 30'h0, 4'b0000, 32'h0,         32'h0000_1234};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'h0000_7F00, 1'b0, 30'h4, 4'b0000, 32'h0,         32'h0000_007F};

    rstN = 1'b0; start = 1'b0; isStore = 1'b0; funct3 = 3'b000;
    addr = 32'h0; storeData = 32'h0;
    memIf.rdata = 32'h0; memIf.ready = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_req", 32'(memIf.req), 32'd0);
    checkOutput("rst_wmask", 32'(memIf.wmask), 32'd0);
    checkOutput("rst_load", loadData, 32'h0);
    rstN = 1'b1;
    nextCycle();

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Timeout: req for cycles 1..4, fault+done at 5; a start while busy is ignored.
    start = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
    memIf.ready = 1'b0;
    nextCycle();
    isStore = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080; storeData = 32'h1111_2222;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("to_c%0d_req", c), 32'(memIf.req), 32'd1);
      checkOutput($sformatf("to_c%0d_done", c), 32'(done), 32'd0);
      checkOutput($sformatf("to_c%0d_maddr", c), 32'(memIf.addr), 32'h10);
      checkOutput($sformatf("to_c%0d_wmask", c), 32'(memIf.wmask), 32'd0);
      nextCycle();
    end
    checkOutput("to_c5_req", 32'(memIf.req), 32'd0);
    checkOutput("to_c5_done", 32'(done), 32'd1);
    checkOutput("to_c5_fault", 32'(fault), 32'd1);
    checkOutput("to_c5_load", loadData, 32'h0000_007F);
    // start still asserted during RESP must not be taken
    isStore = 1'b0; funct3 = 3'b010; addr = 32'h0000_0010;
    nextCycle();
    start = 1'b0;
    checkOutput("to_c6_busy", 32'(busy), 32'd0);
    checkOutput("to_c6_req", 32'(memIf.req), 32'd0);
    checkOutput("to_c6_done", 32'(done), 32'd0);
    nextCycle();

    // Reset during ACCESS: request is abandoned without a done pulse.
    start = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h0000_0050;
    memIf.ready = 1'b0;
    nextCycle();
    start = 1'b0;
    checkOutput("rs_c1_req", 32'(memIf.req), 32'd1);
    rstN = 1'b0;
    nextCycle();
    checkOutput("rs_req", 32'(memIf.req), 32'd0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_done", 32'(done), 32'd0);
    checkOutput("rs_load", loadData, 32'h0);
    rstN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      checkOutput($sformatf("rs_after%0d_done", c), 32'(done), 32'd0);
      checkOutput($sformatf("rs_after%0d_req", c), 32'(memIf.req), 32'd0);
    end

    freshLw = '{1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 1'b0, 30'h4, 4'b0000, 32'h0, 32'h1122_3344};
    applyStimulus(freshLw, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
